clock_select_sequencer: RTL and testbench

- Sequences and arbitrates clock-switch requests for the two-input clock-select mux (clock A / clock B).
- Up to NREQ requesters ask for a target clock. The block grants one request at a time, round-robin.
- For the granted request it issues a one-cycle SELECT/SELECT_ENABLE strobe, then tracks the mux's output-domain reset through assert and release.
- It enforces a minimum dwell time before acknowledging. It sits in the CLK domain beside the mux.

---
 rtl/clock_select_sequencer_pkg.sv | 22 ++
 rtl/clock_select_sequencer_rr_arbiter.sv | 40 ++++
 rtl/clock_select_sequencer.sv | 169 ++++++++++++++++
 tb/tb_clock_select_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_select_sequencer_pkg.sv
// Shared definitions for the clock-select sequencer.
//   - state_t / ST_* : 3-bit sequencer state encoding (7 states)
//   - CLKSEL_A / CLKSEL_B : select values driven to the two-input clock mux
//   - CLKSEL_CW_DEFAULT : default width of the timeout/dwell counter
package clock_select_sequencer_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE         = 3'd0;
    localparam state_t ST_GRANT        = 3'd1;
    localparam state_t ST_ISSUE        = 3'd2;
    localparam state_t ST_WAIT_ASSERT  = 3'd3;
    localparam state_t ST_WAIT_RELEASE = 3'd4;
    localparam state_t ST_DWELL        = 3'd5;
    localparam state_t ST_DONE         = 3'd6;

    localparam logic CLKSEL_A = 1'b1;
    localparam logic CLKSEL_B = 1'b0;

    localparam int CLKSEL_CW_DEFAULT = 8;

endpackage

// File: rtl/clock_select_sequencer_rr_arbiter.sv
// Round-robin priority pick, purely combinational.
//   req   : request vector, NREQ bits
//   ptr   : index with highest priority this round (must be < NREQ)
//   idx   : index of the first set request at or above ptr, wrapping
//   valid : at least one request is set
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    // Rotating the doubled vector puts the request at ptr in bit 0, so the
    // lowest set bit of the rotated window is the round-robin winner.
    logic [2*NREQ-1:0] rot;
    logic [IW:0]       sum;

    assign rot = {req, req} >> ptr;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        sum   = '0;
        // Downward scan so the lowest offset is the last (winning) write.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid = 1'b1;
                sum   = {1'b0, ptr} + (IW + 1)'(k);
                if (sum >= (IW + 1)'(NREQ)) begin
                    sum = sum - (IW + 1)'(NREQ);
                end
                idx = sum[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/clock_select_sequencer.sv
// Clock-select sequencer: arbitrates clock-switch requests round-robin,
// strobes the clock mux select register, tracks the mux output-domain reset
// through assert and release, holds a dwell time, then acknowledges.
//
// Handshake: a requester raises REQ[i] with a stable REQ_SEL[i] and holds
// both until ACK[i] pulses for one cycle; ERR pulses with that ACK if the
// switch was aborted by a reset-tracking timeout. Dropping REQ early does not
// cancel a switch that has already been granted.
//
// Ports:
//   CLK, RST        clock, synchronous active-low reset
//   REQ, REQ_SEL    per-requester request and target (1 = clock A, 0 = clock B)
//   DOMAIN_RST_N    mux output-domain reset, synchronized to CLK
//   ACK, ERR        one-hot completion pulse, abort flag
//   SELECT          select value to the mux (held between strobes)
//   SELECT_ENABLE   one-cycle mux load strobe
//   CUR_SEL         committed selection
//   BUSY            sequencer not idle
//   LOCK, LOCK_BLOCKED  present only when CLKSEL_LOCK_EN is defined:
//                   LOCK=1 holds off new grants; LOCK_BLOCKED flags a
//                   pending request being held off in IDLE.
module clock_select_sequencer
    import clock_select_sequencer_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int CW      = CLKSEL_CW_DEFAULT,
    parameter int TIMEOUT = 200,
    parameter int DWELL   = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NREQ-1:0] REQ,
    input  logic [NREQ-1:0] REQ_SEL,
    input  logic            DOMAIN_RST_N,
`ifdef CLKSEL_LOCK_EN
    input  logic            LOCK,
    output logic            LOCK_BLOCKED,
`endif
    output logic [NREQ-1:0] ACK,
    output logic            ERR,
    output logic            SELECT,
    output logic            SELECT_ENABLE,
    output logic            CUR_SEL,
    output logic            BUSY
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [CW-1:0] TIMEOUT_C  = CW'(TIMEOUT);
    // Unused when DWELL == 0: WAIT_RELEASE then bypasses the DWELL state.
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

    state_t          state;
    logic [IW-1:0]   grant_idx;
    logic            target;
    logic            cur_sel_q;
    logic            select_q;
    logic            err_q;
    logic [IW-1:0]   ptr;
    logic [CW-1:0]   cnt;

    logic [IW-1:0]   win_idx;
    logic            win_valid;
    logic            grant_ok;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req   (REQ),
        .ptr   (ptr),
        .idx   (win_idx),
        .valid (win_valid)
    );

`ifdef CLKSEL_LOCK_EN
    assign grant_ok     = win_valid & ~LOCK;
    assign LOCK_BLOCKED = LOCK & (|REQ) & (state == ST_IDLE);
`else
    assign grant_ok     = win_valid;
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= ST_IDLE;
            grant_idx <= '0;
            target    <= CLKSEL_B;
            cur_sel_q <= CLKSEL_B;
            select_q  <= CLKSEL_B;
            err_q     <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_ok) begin
                        grant_idx <= win_idx;
                        // REQ_SEL is stable while REQ is high, so the target
                        // can be captured together with the winner.
                        target    <= REQ_SEL[win_idx];
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (target == cur_sel_q) begin
                        state <= ST_DONE;
                    end else begin
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // The mux loads its select register on this strobe, so
                    // the new selection is committed here.
                    select_q  <= target;
                    cur_sel_q <= target;
                    cnt       <= '0;
                    state     <= ST_WAIT_ASSERT;
                end
                ST_WAIT_ASSERT: begin
                    if (!DOMAIN_RST_N) begin
                        cnt   <= '0;
                        state <= ST_WAIT_RELEASE;
                    end else if (cnt == TIMEOUT_C) begin
                        err_q <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_WAIT_RELEASE: begin
                    if (DOMAIN_RST_N) begin
                        cnt   <= '0;
                        state <= (DWELL == 0) ? ST_DONE : ST_DWELL;
                    end else if (cnt == TIMEOUT_C) begin
                        err_q <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DWELL: begin
                    if (cnt == DWELL_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    ptr   <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                    err_q <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode directly from registered state, so the ACK/ERR and
    // SELECT_ENABLE pulses are exactly one DONE/ISSUE cycle long.
    assign ACK           = (state == ST_DONE) ? (NREQ'(1) << grant_idx) : '0;
    assign ERR           = (state == ST_DONE) & err_q;
    assign SELECT_ENABLE = (state == ST_ISSUE);
    assign SELECT        = (state == ST_ISSUE) ? target : select_q;
    assign CUR_SEL       = cur_sel_q;
    assign BUSY          = (state != ST_IDLE);

endmodule

// File: tb/tb_clock_select_sequencer.sv
// Self-checking bench for clock_select_sequencer. A behavioural model keeps
// the round-robin pointer and committed clock, and derives expected ACK
// timing from the request cycle and the cycle the mux releases its reset.
// Build with CLKSEL_LOCK_EN defined to include the LOCK scenario.
`timescale 1ns/1ps
module tb_clock_select_sequencer;

    localparam int NREQ    = 2;
    localparam int CW      = 8;
    localparam int TIMEOUT = 200;
    localparam int DWELL   = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] req_sel = '0;
    logic            domain_rst_n = 1'b1;
    logic [NREQ-1:0] ack;
    logic            err;
    logic            select;
    logic            select_enable;
    logic            cur_sel;
    logic            busy;
`ifdef CLKSEL_LOCK_EN
    logic            lock = 1'b0;
    logic            lock_blocked;
`endif

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    // Reference model state
    int   ptr_m = 0;
    logic cur_m = 1'b0;
    logic [NREQ-1:0] exp_q[$];

    // Mux responder behaviour: 0 normal, 1 never asserts reset, 2 never releases
    int mode = 0;
    int a_dly = 3;
    int b_dly = 5;

    clock_select_sequencer #(
        .NREQ    (NREQ),
        .CW      (CW),
        .TIMEOUT (TIMEOUT),
        .DWELL   (DWELL)
    ) dut (
        .CLK           (clk),
        .RST           (rst),
        .REQ           (req),
        .REQ_SEL       (req_sel),
        .DOMAIN_RST_N  (domain_rst_n),
`ifdef CLKSEL_LOCK_EN
        .LOCK          (lock),
        .LOCK_BLOCKED  (lock_blocked),
`endif
        .ACK           (ack),
        .ERR           (err),
        .SELECT        (select),
        .SELECT_ENABLE (select_enable),
        .CUR_SEL       (cur_sel),
        .BUSY          (busy)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- model helpers ----------------
    function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
        for (int k = 0; k < NREQ; k++) begin
            int c;
            c = (p + k) % NREQ;
            if (m[c]) return c;
        end
        return -1;
    endfunction

    // ---------------- driver: acts as the clock mux ----------------
    // Runs on negedges until an ACK appears or the budget expires. Records
    // strobe, reset-assert and reset-release cycles for timing checks.
    task automatic serve(input bit keep,
                         output logic [NREQ-1:0] ack_o, output logic err_o,
                         output int ack_c, output int se_n, output int se_c,
                         output logic se_v, output int low_c, output int rel_c);
        int low_at;
        int rel_at;
        ack_o = '0; err_o = 1'b0; ack_c = -1; se_n = 0; se_c = -1;
        se_v = 1'b0; low_c = -1; rel_c = -1; low_at = -1; rel_at = -1;
        for (int i = 0; i < 2 * TIMEOUT + 100; i++) begin
            @(negedge clk);
            if (select_enable) begin
                se_n++;
                se_c = cyc;
                se_v = select;
                if (mode != 1) low_at = cyc + a_dly;
            end
            if (cyc == low_at) begin
                domain_rst_n = 1'b0;
                low_c = cyc;
                if (mode != 2) rel_at = cyc + b_dly;
            end
            if (cyc == rel_at) begin
                domain_rst_n = 1'b1;
                rel_c = cyc;
            end
            if (ack != '0) begin
                ack_o = ack;
                err_o = err;
                ack_c = cyc;
                if (!keep) req = req & ~ack;
                domain_rst_n = 1'b1;
                return;
            end
        end
    endtask

    // Serves n grants of a normal (non-timeout) workload whose requests were
    // visible to an idle sequencer from cycle start.
    task automatic run_pending(input int start, input int n, input bit keep,
                               input logic [NREQ-1:0] mask_in, input string tag);
        logic [NREQ-1:0] pend;
        logic [NREQ-1:0] ack_o;
        logic [NREQ-1:0] exp_ack;
        logic err_o, se_v, sw;
        int ack_c, se_n, se_c, low_c, rel_c, st, w, exp_c;
        pend = mask_in;
        st = start;
        for (int t = 0; t < n; t++) begin
            w = rr_pick(pend, ptr_m);
            sw = (req_sel[w] != cur_m);
            exp_q.push_back(NREQ'(1) << w);
            serve(keep, ack_o, err_o, ack_c, se_n, se_c, se_v, low_c, rel_c);
            exp_ack = exp_q.pop_front();
            n_checks++;
            if (ack_o !== exp_ack) begin
                n_fail++;
                $display("FAIL %s ack[%0d]: got %b expected %b", tag, t, ack_o, exp_ack);
            end
            n_checks++;
            if (err_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s err[%0d]: got %b expected 0", tag, t, err_o);
            end
            n_checks++;
            if (se_n != (sw ? 1 : 0)) begin
                n_fail++;
                $display("FAIL %s strobe_count[%0d]: got %0d expected %0d", tag, t, se_n, sw ? 1 : 0);
            end
            if (sw) begin
                n_checks++;
                if (se_c != st + 2 || se_v !== req_sel[w]) begin
                    n_fail++;
                    $display("FAIL %s strobe[%0d]: got cycle %0d value %b expected cycle %0d value %b",
                             tag, t, se_c, se_v, st + 2, req_sel[w]);
                end
                exp_c = rel_c + 1 + DWELL;
            end else begin
                exp_c = st + 2;
            end
            n_checks++;
            if (ack_c != exp_c) begin
                n_fail++;
                $display("FAIL %s ack_cycle[%0d]: got %0d expected %0d", tag, t, ack_c, exp_c);
            end
            ptr_m = (w + 1) % NREQ;
            if (sw) cur_m = req_sel[w];
            n_checks++;
            if (cur_sel !== cur_m) begin
                n_fail++;
                $display("FAIL %s cur_sel[%0d]: got %b expected %b", tag, t, cur_sel, cur_m);
            end
            if (!keep) pend[w] = 1'b0;
            st = ack_c + 1;
        end
    endtask

    task automatic do_requests(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] sel,
                               input int n, input string tag);
        @(negedge clk);
        req_sel = sel;
        req = mask;
        run_pending(cyc, n, 1'b0, mask, tag);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ack !== '0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ack_err: got ack=%b err=%b expected 0 0", ack, err);
        end
        n_checks++;
        if (select !== 1'b0 || select_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_select: got sel=%b en=%b expected 0 0", select, select_enable);
        end
        n_checks++;
        if (cur_sel !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cur_busy: got cur=%b busy=%b expected 0 0", cur_sel, busy);
        end
        rst = 1'b1;
        ptr_m = 0;
        cur_m = 1'b0;
    endtask

    task automatic test_same_clock();
        mode = 0;
        do_requests(2'b01, 2'b00, 1, "same_clock");
    endtask

    task automatic test_normal_switch();
        mode = 0;
        a_dly = 3;
        b_dly = 5;
        do_requests(2'b01, 2'b01, 1, "normal_switch");
    endtask

    task automatic test_timeout(input int which);
        logic [NREQ-1:0] ack_o;
        logic err_o, se_v, tgt;
        int ack_c, se_n, se_c, low_c, rel_c, start, r, exp_c;
        mode = which;
        a_dly = 2;
        r = ptr_m;
        tgt = ~cur_m;
        @(negedge clk);
        req_sel = '0;
        req_sel[r] = tgt;
        req = NREQ'(1) << r;
        start = cyc;
        serve(1'b0, ack_o, err_o, ack_c, se_n, se_c, se_v, low_c, rel_c);
        // WAIT_ASSERT starts the cycle after the strobe; WAIT_RELEASE the cycle
        // after reset was seen low. Each lasts TIMEOUT+1 cycles, then DONE.
        if (which == 1) exp_c = start + 2 + 2 + TIMEOUT;
        else            exp_c = start + 2 + a_dly + 2 + TIMEOUT;
        n_checks++;
        if (ack_o !== (NREQ'(1) << r) || err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout%0d_ack_err: got ack=%b err=%b expected %b 1", which, ack_o, err_o, NREQ'(1) << r);
        end
        n_checks++;
        if (ack_c != exp_c) begin
            n_fail++;
            $display("FAIL timeout%0d_cycle: got %0d expected %0d", which, ack_c, exp_c);
        end
        ptr_m = (r + 1) % NREQ;
        cur_m = tgt;
        n_checks++;
        if (cur_sel !== cur_m) begin
            n_fail++;
            $display("FAIL timeout%0d_cur_sel: got %b expected %b", which, cur_sel, cur_m);
        end
        mode = 0;
    endtask

    task automatic test_reset_mid_op();
        int r;
        bit seen;
        r = ptr_m;
        seen = 0;
        @(negedge clk);
        req_sel = '0;
        req_sel[r] = ~cur_m;
        req = NREQ'(1) << r;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (select_enable) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL midreset_strobe: got none expected strobe within 10 cycles");
        end
        repeat (2) @(negedge clk);
        domain_rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (ack !== '0) begin
                n_fail++;
                $display("FAIL midreset_no_ack[%0d]: got %b expected 0", i, ack);
            end
        end
        rst = 1'b0;
        req = '0;
        @(negedge clk);
        n_checks++;
        if (ack !== '0 || err !== 1'b0 || select !== 1'b0 || select_enable !== 1'b0
            || cur_sel !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got ack=%b err=%b sel=%b en=%b cur=%b busy=%b expected all 0",
                     ack, err, select, select_enable, cur_sel, busy);
        end
        rst = 1'b1;
        domain_rst_n = 1'b1;
        ptr_m = 0;
        cur_m = 1'b0;
    endtask

    task automatic test_fairness();
        mode = 0;
        a_dly = $urandom_range(1, 6);
        b_dly = $urandom_range(1, 6);
        @(negedge clk);
        req_sel = 2'b10;
        req = 2'b11;
        run_pending(cyc, 3, 1'b1, 2'b11, "fairness");
        req = '0;
    endtask

    task automatic test_random();
        logic [NREQ-1:0] mask;
        logic [NREQ-1:0] sel;
        mode = 0;
        for (int i = 0; i < 10; i++) begin
            a_dly = $urandom_range(1, 6);
            b_dly = $urandom_range(1, 6);
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            sel = NREQ'($urandom);
            do_requests(mask, sel, $countones(mask), "random");
        end
    endtask

`ifdef CLKSEL_LOCK_EN
    task automatic test_lock();
        int r;
        r = ptr_m;
        mode = 0;
        a_dly = 2;
        b_dly = 3;
        @(negedge clk);
        lock = 1'b1;
        req_sel = '0;
        req_sel[r] = ~cur_m;
        req = NREQ'(1) << r;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (lock_blocked !== 1'b1 || busy !== 1'b0 || ack !== '0) begin
                n_fail++;
                $display("FAIL lock_hold[%0d]: got blocked=%b busy=%b ack=%b expected 1 0 0",
                         i, lock_blocked, busy, ack);
            end
        end
        lock = 1'b0;
        run_pending(cyc, 1, 1'b0, NREQ'(1) << r, "lock_release");
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_same_clock();
        test_normal_switch();
        test_timeout(1);
        test_reset_mid_op();
        test_fairness();
        test_timeout(2);
        test_random();
`ifdef CLKSEL_LOCK_EN
        test_lock();
`endif
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
